dmem_ctrl: RTL and testbench

//  Data-memory responder for the RV32I pipeline; serves the memory-access stage.
//  - Captures load requests from the ALU/access stage and store requests from the memory stage.
//  - Runs them on a single-outstanding REQ/ACK data bus.
//  - Returns byte-lane-aligned, sign/zero-extended load data on RDDATA for the memory stage.
//  - Freezes the pipeline via STALL while a bus transaction is in flight.

---
 rtl/dmem_ctrl_pkg.sv | 36 +++
 rtl/dmem_ctrl_if.sv | 25 ++
 rtl/dmem_load_fmt.sv | 27 ++
 rtl/dmem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: load size codes, FSM
// encoding and the access-alignment helpers used by the optional checker.
package dmem_ctrl_pkg;

    localparam logic [1:0] LSZ_B = 2'b00;
    localparam logic [1:0] LSZ_H = 2'b01;
    localparam logic [1:0] LSZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } dmem_state_t;

    // Size code 2'b11 behaves as a word access.
    function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            LSZ_B:   bad = 1'b0;
            LSZ_H:   bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic strb_misaligned(input logic [3:0] strb);
        logic bad;
        case (strb)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: bad = 1'b0;
            default:                            bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Single-outstanding data bus between the controller (master) and data memory (slave).
interface dmem_ctrl_if #(
    parameter int AW = 32
);
    // REQ is the valid: once raised, WE/ADDR/STRB/WDATA stay constant until a
    // clock edge where ACK=1 (ACK may already be high in the first REQ cycle);
    // RDATA is only meaningful in that ACK cycle of a read.
    logic          DMEM_REQ;
    logic          DMEM_WE;
    logic [AW-1:0] DMEM_ADDR;
    logic [3:0]    DMEM_STRB;
    logic [31:0]   DMEM_WDATA;
    logic [31:0]   DMEM_RDATA;
    logic          DMEM_ACK;

    modport master (
        output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_STRB, DMEM_WDATA,
        input  DMEM_RDATA, DMEM_ACK
    );

    modport slave (
        input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_STRB, DMEM_WDATA,
        output DMEM_RDATA, DMEM_ACK
    );
endinterface

// File: rtl/dmem_load_fmt.sv
// Load-data formatter: selects the addressed byte/half/word lane of a bus word
// and sign- or zero-extends it to 32 bits.
module dmem_load_fmt
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [31:0] w_lane;

    // A word load at a nonzero offset leaves the vacated top bytes at zero.
    assign w_lane = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = w_lane;
        case (i_size)
            LSZ_B:   o_data = {{24{i_signed & w_lane[7]}},  w_lane[7:0]};
            LSZ_H:   o_data = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
            default: o_data = w_lane;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the RV32I memory-access stage: runs captured
// stores and loads on the dmem bus and stalls the pipeline while busy.
// Optional misalignment flag enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              HOLD,
    input  logic              FLUSH,
    output logic              STALL,
    input  logic              RD_EN,
    input  logic [31:0]       RD_ADDR,
    input  logic [1:0]        RD_SIZE,
    input  logic              RD_SIGNED,
    output logic [31:0]       RDDATA,
    input  logic              WR_EN,
    input  logic [31:0]       WR_ADDR,
    input  logic [3:0]        WR_STRB,
    input  logic [31:0]       WR_DATA,
    dmem_ctrl_if.master       bus,
    output logic              MISALIGN,
    output dmem_state_t       o_dbg_state
);

    dmem_state_t   r_state;
    logic          r_pend_rd;
    logic [AW-1:0] r_rd_addr;
    logic [1:0]    r_rd_off;
    logic [1:0]    r_rd_size;
    logic          r_rd_signed;
    logic [31:0]   r_rddata;
    logic          r_req;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_strb;
    logic [31:0]   r_wdata;

    logic          w_adv;
    logic          w_rd_take;
    logic [AW-1:0] w_rd_word;
    logic [AW-1:0] w_wr_word;
    logic [31:0]   w_fmt;
    logic          w_unused_wr_lsb;

    assign w_adv           = (r_state == ST_IDLE) && !HOLD;
    assign w_rd_take       = RD_EN && !FLUSH;
    assign w_rd_word       = {RD_ADDR[AW-1:2], 2'b00};
    assign w_wr_word       = {WR_ADDR[AW-1:2], 2'b00};
    assign w_unused_wr_lsb = ^WR_ADDR[1:0];

    dmem_load_fmt u_fmt (
        .i_rdata  (bus.DMEM_RDATA),
        .i_off    (r_rd_off),
        .i_size   (r_rd_size),
        .i_signed (r_rd_signed),
        .o_data   (w_fmt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_pend_rd   <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_off    <= 2'b00;
            r_rd_size   <= LSZ_B;
            r_rd_signed <= 1'b0;
            r_rddata    <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_strb      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_adv) begin
                        if (w_rd_take) begin
                            r_rd_addr   <= w_rd_word;
                            r_rd_off    <= RD_ADDR[1:0];
                            r_rd_size   <= RD_SIZE;
                            r_rd_signed <= RD_SIGNED;
                        end
                        // The store is older than a same-edge load, so it goes first.
                        if (WR_EN) begin
                            r_req     <= 1'b1;
                            r_we      <= 1'b1;
                            r_addr    <= w_wr_word;
                            r_strb    <= WR_STRB;
                            r_wdata   <= WR_DATA;
                            r_pend_rd <= w_rd_take;
                            r_state   <= ST_WR;
                        end else if (w_rd_take) begin
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_addr  <= w_rd_word;
                            r_strb  <= '0;
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    if (bus.DMEM_ACK) begin
                        if (r_pend_rd) begin
                            r_pend_rd <= 1'b0;
                            r_we      <= 1'b0;
                            r_addr    <= r_rd_addr;
                            r_strb    <= '0;
                            r_state   <= ST_RD;
                        end else begin
                            r_req   <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RD: begin
                    if (bus.DMEM_ACK) begin
                        r_rddata <= w_fmt;
                        r_req    <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    logic r_misalign;

    // Flags the access but does not block it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_adv &&
                          ((WR_EN && strb_misaligned(WR_STRB)) ||
                           (w_rd_take && load_misaligned(RD_SIZE, RD_ADDR[1:0])));
        end
    end

    assign MISALIGN = r_misalign;
`else
    assign MISALIGN = 1'b0;
`endif

    assign STALL          = (r_state != ST_IDLE);
    assign RDDATA         = r_rddata;
    assign o_dbg_state    = r_state;
    assign bus.DMEM_REQ   = r_req;
    assign bus.DMEM_WE    = r_we;
    assign bus.DMEM_ADDR  = r_addr;
    assign bus.DMEM_STRB  = r_strb;
    assign bus.DMEM_WDATA = r_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus a randomized run against a
// behavioural load/store model and a bus responder with variable ACK delay.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        HOLD;
    logic        FLUSH;
    logic        STALL;
    logic        RD_EN;
    logic [31:0] RD_ADDR;
    logic [1:0]  RD_SIZE;
    logic        RD_SIGNED;
    logic [31:0] RDDATA;
    logic        WR_EN;
    logic [31:0] WR_ADDR;
    logic [3:0]  WR_STRB;
    logic [31:0] WR_DATA;
    logic        MISALIGN;
    dmem_state_t o_dbg_state;

    dmem_ctrl_if #(.AW(32)) bus ();

    dmem_ctrl #(.AW(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .HOLD        (HOLD),
        .FLUSH       (FLUSH),
        .STALL       (STALL),
        .RD_EN       (RD_EN),
        .RD_ADDR     (RD_ADDR),
        .RD_SIZE     (RD_SIZE),
        .RD_SIGNED   (RD_SIGNED),
        .RDDATA      (RDDATA),
        .WR_EN       (WR_EN),
        .WR_ADDR     (WR_ADDR),
        .WR_STRB     (WR_STRB),
        .WR_DATA     (WR_DATA),
        .bus         (bus),
        .MISALIGN    (MISALIGN),
        .o_dbg_state (o_dbg_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_txn_t;

    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 0;
    logic [31:0] rd_word = 32'h0;
    bus_txn_t    log_q[$];
    logic [31:0] exp_q[$];

    // Memory responder: ACKs after ack_delay waiting cycles and logs every completed transfer.
    initial begin
        int cnt;
        cnt = 0;
        bus.DMEM_ACK   = 1'b0;
        bus.DMEM_RDATA = 32'h0;
        forever begin
            @(negedge CLK);
            if (bus.DMEM_REQ === 1'b1) begin
                if (cnt >= ack_delay) begin
                    bus.DMEM_ACK   = 1'b1;
                    bus.DMEM_RDATA = bus.DMEM_WE ? 32'hDEAD_BEEF : rd_word;
                    log_q.push_back('{we: bus.DMEM_WE, addr: bus.DMEM_ADDR,
                                      strb: bus.DMEM_STRB, wdata: bus.DMEM_WDATA});
                    cnt = 0;
                end else begin
                    bus.DMEM_ACK = 1'b0;
                    cnt++;
                end
            end else begin
                bus.DMEM_ACK = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_fmt(input logic [31:0] w, input int off,
                                            input int size, input bit sgn);
        logic [31:0] sh;
        longint      v;
        sh = w >> (8 * off);
        if (size == 0) begin
            v = sh % 256;
            if (sgn && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = sh % 65536;
            if (sgn && v >= 32768) v = v - 65536;
        end else begin
            v = sh;
        end
        return v[31:0];
    endfunction

    function automatic bit ref_misalign(input bit wr, input logic [3:0] strb, input bit rd,
                                        input int size, input int off);
        bit bad_st, bad_ld;
        bad_st = wr && !(strb inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                      4'b1000, 4'b0011, 4'b1100, 4'b1111});
        bad_ld = rd && ((size == 1 && off % 2 == 1) || (size >= 2 && off != 0));
        return bad_st || bad_ld;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (STALL === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic issue(input logic wr, input logic rd, input logic fl,
                         input logic [31:0] wa, input logic [3:0] ws, input logic [31:0] wd,
                         input logic [31:0] ra, input logic [1:0] rs, input logic rsg,
                         output logic mis, output int stalls);
        WR_EN = wr; WR_ADDR = wa; WR_STRB = ws; WR_DATA = wd;
        RD_EN = rd; RD_ADDR = ra; RD_SIZE = rs; RD_SIGNED = rsg;
        FLUSH = fl;
        tick();
        mis = MISALIGN;
        WR_EN = 1'b0; RD_EN = 1'b0; FLUSH = 1'b0;
        wait_idle(stalls);
    endtask

    task automatic test_reset();
        RST = 1'b1; RD_EN = 1'b1; RD_ADDR = 32'h0000_0040; RD_SIZE = 2'b10;
        rd_word = 32'h1111_2222;
        repeat (3) tick();
        checks++; if (bus.DMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.DMEM_REQ); end
        checks++; if (bus.DMEM_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.DMEM_WE); end
        checks++; if (bus.DMEM_ADDR !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.DMEM_ADDR); end
        checks++; if (bus.DMEM_STRB !== 4'h0) begin errors++; $display("FAIL reset_strb: got %h expected 0", bus.DMEM_STRB); end
        checks++; if (bus.DMEM_WDATA !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.DMEM_WDATA); end
        checks++; if (RDDATA !== 32'h0) begin errors++; $display("FAIL reset_rddata: got %h expected 0", RDDATA); end
        checks++; if (STALL !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", STALL); end
        checks++; if (MISALIGN !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", MISALIGN); end
        checks++; if (o_dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", o_dbg_state, ST_IDLE); end
        RST = 1'b0;
        tick();
        RD_EN = 1'b0;
        checks++; if (bus.DMEM_REQ !== 1'b1 || bus.DMEM_ADDR !== 32'h40) begin
            errors++; $display("FAIL post_reset_req: got req=%b addr=%h expected req=1 addr=00000040", bus.DMEM_REQ, bus.DMEM_ADDR);
        end
        begin
            int n;
            wait_idle(n);
        end
        log_q.delete();
    endtask

    task automatic test_lb_signed();
        logic mis;
        int   n;
        ack_delay = 0; rd_word = 32'h80FF_1234; log_q.delete();
        issue(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0000_0103, 2'b00, 1'b1, mis, n);
        checks++; if (RDDATA !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rddata: got %h expected ffffff80", RDDATA); end
        checks++; if (n != 1) begin errors++; $display("FAIL lb_stall: got %0d expected 1", n); end
        checks++; if (log_q.size() != 1 || log_q[0].we !== 1'b0 || log_q[0].addr !== 32'h100 || log_q[0].strb !== 4'h0) begin
            errors++; $display("FAIL lb_bus: got %0d txns expected one read at 00000100 strb 0", log_q.size());
        end
    endtask

    task automatic test_lhu_wait();
        int n;
        bit addr_ok;
        ack_delay = 3; rd_word = 32'h8001_0000; log_q.delete();
        RD_EN = 1'b1; RD_ADDR = 32'h0000_0102; RD_SIZE = 2'b01; RD_SIGNED = 1'b0;
        tick();
        RD_EN = 1'b0;
        n = 0; addr_ok = 1'b1;
        while (STALL === 1'b1 && n < 64) begin
            if (bus.DMEM_ADDR !== 32'h100 || bus.DMEM_REQ !== 1'b1) addr_ok = 1'b0;
            n++;
            tick();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL lhu_stall: got %0d expected 4", n); end
        checks++; if (!addr_ok) begin errors++; $display("FAIL lhu_addr_hold: got unstable addr/req expected 00000100 held"); end
        checks++; if (RDDATA !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rddata: got %h expected 00008001", RDDATA); end
        ack_delay = 0;
    endtask

    task automatic test_store_load();
        logic mis;
        int   n;
        ack_delay = 0; rd_word = 32'h1357_9BDF; log_q.delete();
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_0000,
              32'h0000_0300, 2'b10, 1'b0, mis, n);
        checks++; if (n != 2) begin errors++; $display("FAIL st_ld_stall: got %0d expected 2", n); end
        checks++; if (log_q.size() != 2) begin
            errors++; $display("FAIL st_ld_count: got %0d expected 2", log_q.size());
        end else begin
            checks++; if (log_q[0].we !== 1'b1 || log_q[0].addr !== 32'h200 || log_q[0].strb !== 4'b1100 || log_q[0].wdata !== 32'hABCD_0000) begin
                errors++; $display("FAIL st_first: got we=%b addr=%h strb=%b wdata=%h expected 1 00000200 1100 abcd0000",
                                   log_q[0].we, log_q[0].addr, log_q[0].strb, log_q[0].wdata);
            end
            checks++; if (log_q[1].we !== 1'b0 || log_q[1].addr !== 32'h300 || log_q[1].strb !== 4'h0) begin
                errors++; $display("FAIL ld_second: got we=%b addr=%h strb=%b expected 0 00000300 0000",
                                   log_q[1].we, log_q[1].addr, log_q[1].strb);
            end
        end
        checks++; if (RDDATA !== 32'h1357_9BDF) begin errors++; $display("FAIL st_ld_rddata: got %h expected 13579bdf", RDDATA); end
    endtask

    task automatic test_flush_hold();
        int n;
        ack_delay = 1; rd_word = 32'h0BAD_F00D; log_q.delete();
        RD_EN = 1'b1; RD_ADDR = 32'h0000_0400; RD_SIZE = 2'b10; RD_SIGNED = 1'b0; FLUSH = 1'b1;
        tick();
        checks++; if (STALL !== 1'b0 || bus.DMEM_REQ !== 1'b0) begin
            errors++; $display("FAIL flush_nocap: got stall=%b req=%b expected 0 0", STALL, bus.DMEM_REQ);
        end
        FLUSH = 1'b0; HOLD = 1'b1;
        tick();
        tick();
        checks++; if (STALL !== 1'b0 || bus.DMEM_REQ !== 1'b0) begin
            errors++; $display("FAIL hold_nocap: got stall=%b req=%b expected 0 0", STALL, bus.DMEM_REQ);
        end
        HOLD = 1'b0;
        tick();
        RD_EN = 1'b0;
        checks++; if (STALL !== 1'b1) begin errors++; $display("FAIL hold_release_cap: got %b expected 1", STALL); end
        wait_idle(n);
        repeat (2) tick();
        checks++; if (log_q.size() != 1) begin errors++; $display("FAIL hold_one_read: got %0d expected 1", log_q.size()); end
        checks++; if (RDDATA !== 32'h0BAD_F00D) begin errors++; $display("FAIL hold_rddata: got %h expected 0badf00d", RDDATA); end
        ack_delay = 0;
    endtask

    task automatic test_rst_abort();
        ack_delay = 10; rd_word = 32'h5555_AAAA; log_q.delete();
        RD_EN = 1'b1; RD_ADDR = 32'h0000_0500; RD_SIZE = 2'b10; RD_SIGNED = 1'b0;
        tick();
        RD_EN = 1'b0;
        checks++; if (bus.DMEM_REQ !== 1'b1) begin errors++; $display("FAIL abort_req_on: got %b expected 1", bus.DMEM_REQ); end
        tick();
        RST = 1'b1;
        tick();
        checks++; if (bus.DMEM_REQ !== 1'b0 || RDDATA !== 32'h0 || STALL !== 1'b0) begin
            errors++; $display("FAIL abort: got req=%b rddata=%h stall=%b expected 0 00000000 0", bus.DMEM_REQ, RDDATA, STALL);
        end
        RST = 1'b0;
        repeat (3) tick();
        checks++; if (bus.DMEM_REQ !== 1'b0 || log_q.size() != 0) begin
            errors++; $display("FAIL abort_discard: got req=%b txns=%0d expected 0 0", bus.DMEM_REQ, log_q.size());
        end
        ack_delay = 0;
    endtask

`ifdef DMEM_MISALIGN_CHK_EN
    task automatic test_misalign();
        int n;
        rd_word = 32'h0102_0304; log_q.delete();
        RD_EN = 1'b1; RD_ADDR = 32'h0000_0101; RD_SIZE = 2'b10; RD_SIGNED = 1'b0;
        tick();
        RD_EN = 1'b0;
        checks++; if (MISALIGN !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b expected 1", MISALIGN); end
        tick();
        checks++; if (MISALIGN !== 1'b0) begin errors++; $display("FAIL misalign_end: got %b expected 0", MISALIGN); end
        wait_idle(n);
    endtask
`endif

    task automatic test_random();
        logic        mis;
        int          n, d, size, off, exp_stalls;
        bit          wr, rd, fl, rd_take, exp_mis;
        logic [31:0] wa, wd, ra, got_exp;
        logic [3:0]  ws;
        for (int i = 0; i < 40; i++) begin
            wr   = ($urandom_range(0, 1) == 1);
            rd   = (i == 0) || ($urandom_range(0, 3) != 0);
            fl   = (i != 0) && ($urandom_range(0, 3) == 0);
            d    = $urandom_range(0, 3);
            size = $urandom_range(0, 3);
            wa   = $urandom();
            ra   = $urandom();
            wd   = $urandom();
            ws   = 4'($urandom_range(0, 15));
            off  = int'(ra % 4);
            ack_delay = d;
            rd_word   = $urandom();
            log_q.delete();
            rd_take = rd && !fl;
            issue(wr, rd, fl, wa, ws, wd, ra, 2'(size), 1'($urandom_range(0, 1)), mis, n);
            exp_stalls = (wr ? d + 1 : 0) + (rd_take ? d + 1 : 0);
`ifdef DMEM_MISALIGN_CHK_EN
            exp_mis = ref_misalign(wr, ws, rd_take, size, off);
`else
            exp_mis = 1'b0;
`endif
            checks++; if (n != exp_stalls) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", i, n, exp_stalls); end
            checks++; if (mis !== exp_mis) begin errors++; $display("FAIL rnd_misalign[%0d]: got %b expected %b", i, mis, exp_mis); end
            checks++; if (log_q.size() != int'(wr) + int'(rd_take)) begin
                errors++; $display("FAIL rnd_txns[%0d]: got %0d expected %0d", i, log_q.size(), int'(wr) + int'(rd_take));
            end else begin
                if (wr) begin
                    checks++; if (log_q[0].we !== 1'b1 || log_q[0].addr !== (wa & 32'hFFFF_FFFC) || log_q[0].strb !== ws || log_q[0].wdata !== wd) begin
                        errors++; $display("FAIL rnd_store[%0d]: got addr=%h strb=%b wdata=%h expected %h %b %h",
                                           i, log_q[0].addr, log_q[0].strb, log_q[0].wdata, wa & 32'hFFFF_FFFC, ws, wd);
                    end
                end
                if (rd_take) begin
                    checks++; if (log_q[log_q.size()-1].we !== 1'b0 || log_q[log_q.size()-1].addr !== (ra & 32'hFFFF_FFFC) || log_q[log_q.size()-1].strb !== 4'h0) begin
                        errors++; $display("FAIL rnd_load[%0d]: got addr=%h expected %h", i, log_q[log_q.size()-1].addr, ra & 32'hFFFF_FFFC);
                    end
                end
            end
            // A load updates the expected read data; anything else must leave it unchanged.
            if (rd_take) exp_q.push_back(ref_fmt(rd_word, off, size, RD_SIGNED));
            else         exp_q.push_back(got_exp);
            got_exp = exp_q.pop_front();
            checks++; if (RDDATA !== got_exp) begin errors++; $display("FAIL rnd_rddata[%0d]: got %h expected %h", i, RDDATA, got_exp); end
        end
        ack_delay = 0;
    endtask

    initial begin
        RST = 1'b1; HOLD = 1'b0; FLUSH = 1'b0;
        RD_EN = 1'b0; RD_ADDR = '0; RD_SIZE = '0; RD_SIGNED = 1'b0;
        WR_EN = 1'b0; WR_ADDR = '0; WR_STRB = '0; WR_DATA = '0;
        test_reset();
        test_lb_signed();
        test_lhu_wait();
        test_store_load();
        test_flush_hold();
        test_rst_abort();
`ifdef DMEM_MISALIGN_CHK_EN
        test_misalign();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
